pipo_rr_load_arbiter: RTL
=========================

// Module: pipo_rr_load_arbiter
// PURPOSE
//  Shares one WIDTH-bit parallel-in/parallel-out holding register among NREQ requesters.
//  Requesters raise req[i] with req_data[i]. A round-robin arbiter picks one, loads its
//  data into the register and acknowledges it with a one-cycle gnt pulse.
//  The loaded value is then held for HOLD_CYCLES cycles before the next load is allowed.
//  Sits between producer blocks and the PIPO storage stage; d_out feeds downstream logic.
// PARAMETERS
//  NREQ         4   number of requesters (>=2)
//  WIDTH        4   data width of the shared register
//  HOLD_CYCLES  2   cycles a loaded value is guaranteed stable before the next load (>=1)
//  (localparam OW = $clog2(NREQ), width of owner)
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           asynchronous, active-high reset
//  req       in   NREQ        load request per requester, level, held until gnt
//  req_data  in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH], stable while req[i]=1
//  clear     in   1           synchronous clear of register and FSM, priority over req
//  gnt       out  NREQ        one-hot, registered; 1-cycle ack pulse to the loaded requester
//  d_out     out  WIDTH       registered shared-register contents
//  owner     out  OW          index of the requester whose data is in d_out
//  valid     out  1           d_out holds loaded data (0 after reset/clear)
//  busy      out  1           1 while in HOLD (loads blocked)
// BEHAVIOUR
//  Reset (async, immediate): d_out=0, gnt=0, owner=0, valid=0, busy=0, ptr=0, hold_cnt=0, state=IDLE.
//  FSM states: IDLE, HOLD. busy = (state==HOLD).
//  IDLE:
//    clear=1          -> d_out=0, valid=0, gnt=0; stay IDLE.
//    |req=1           -> capture the winner's data at this edge and enter HOLD.
//    no req           -> stay IDLE; d_out is unchanged.
//  Capture on winner w:
//    d_out=req_data[w], owner=w, valid=1, gnt=(1<<w) for exactly one cycle,
//    ptr=(w+1)%NREQ, hold_cnt=HOLD_CYCLES-1.
//  Arbitration:
//    Winner is the first set req bit at or after ptr, searching upward with wrap to 0.
//    Fully combinational over req and ptr.
//  Latency:
//    req seen in IDLE at cycle t -> gnt, d_out, owner, valid and busy update in cycle t+1.
//  HOLD:
//    hold_cnt counts down each cycle. At hold_cnt==0, state goes to IDLE at the next edge.
//    Total HOLD = HOLD_CYCLES cycles. Back-to-back loads are spaced HOLD_CYCLES+1 cycles.
//    req is ignored throughout HOLD, including req still high in the gnt cycle.
//    Requesters drop req[i] after seeing gnt[i]. Unserved requesters keep req high.
//  clear in HOLD:
//    d_out=0, valid=0, gnt=0, hold_cnt=0, state=IDLE at the next edge.
//    ptr and owner are unchanged.
//    A pending req is first granted at the edge after clear deasserts.
//  gnt is never asserted in a cycle where clear was sampled high.
//  Simultaneous requests resolve by ptr only; no requester starves.
//    Worst-case wait = (NREQ-1)*(HOLD_CYCLES+1) cycles from IDLE.
//  ptr wraps NREQ-1 -> 0.
//  Reset mid-HOLD aborts the hold immediately. gnt may be cut short; no load survives.
// TESTING
//  1. Reset: assert reset mid-HOLD (d_out=4'b1010) -> d_out=0, valid=0, busy=0, gnt=0 before the next edge.
//  2. Single request: req=4'b0001, data0=4'b1001 in IDLE at cycle t
//       -> t+1: gnt=4'b0001, d_out=4'b1001, owner=0, valid=1, busy=1 for 2 cycles; IDLE at t+3.
//  3. All requesting: req=4'b1111, data i = 4'h1..4'h4 held
//       -> grants 0,1,2,3,0 at cycles t+1, t+4, t+7, t+10, t+13; d_out 1,2,3,4,1.
//  4. Wrap: after a grant to 3, req=4'b1001 -> next grant to 0, then 3; owner follows.
//  5. Clear in HOLD: clear=1 one cycle with req[2] pending
//       -> d_out=0, valid=0, IDLE next cycle; gnt=4'b0100 one cycle after clear drops.
//  6. Clear vs req in IDLE: clear=1 and req=4'b0010 in the same cycle
//       -> no gnt, d_out=0; grant to 1 the cycle after clear deasserts.

Source files
------------

// File: rtl/pipo_rr_load_arbiter.sv
// Shared WIDTH-bit holding register loaded by a round-robin pick among NREQ requesters.
// A load is acked with a one-cycle gnt and is held stable for HOLD_CYCLES cycles.
module pipo_rr_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2,
    localparam int OW         = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic                    clear,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        d_out,
    output logic [OW-1:0]           owner,
    output logic                    valid,
    output logic                    busy
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t           r_state, w_state_nxt;
    logic [OW-1:0]    r_ptr, w_ptr_nxt;
    logic [HCW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [WIDTH-1:0] r_dout, w_dout_nxt;
    logic [OW-1:0]    r_owner, w_owner_nxt;
    logic             r_valid, w_valid_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;

    logic             w_found;
    logic [OW-1:0]    w_win;
    logic [WIDTH-1:0] w_win_data;

    // First set request at or after r_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found    = 1'b1;
                w_win      = OW'((int'(r_ptr) + k) % NREQ);
                w_win_data = req_data[((int'(r_ptr) + k) % NREQ) * WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_dout_nxt     = r_dout;
        w_owner_nxt    = r_owner;
        w_valid_nxt    = r_valid;
        w_gnt_nxt      = '0;
        if (clear) begin
            // ptr and owner survive a clear so fairness is not reset.
            w_dout_nxt     = '0;
            w_valid_nxt    = 1'b0;
            w_hold_cnt_nxt = '0;
            w_state_nxt    = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        w_dout_nxt       = w_win_data;
                        w_owner_nxt      = w_win;
                        w_valid_nxt      = 1'b1;
                        w_gnt_nxt[w_win] = 1'b1;
                        w_ptr_nxt        = OW'((int'(w_win) + 1) % NREQ);
                        w_hold_cnt_nxt   = HCW'(HOLD_CYCLES - 1);
                        w_state_nxt      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0)
                        w_state_nxt = S_IDLE;
                    else
                        w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_dout     <= '0;
            r_owner    <= '0;
            r_valid    <= 1'b0;
            r_gnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_dout     <= w_dout_nxt;
            r_owner    <= w_owner_nxt;
            r_valid    <= w_valid_nxt;
            r_gnt      <= w_gnt_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign d_out = r_dout;
    assign owner = r_owner;
    assign valid = r_valid;
    assign busy  = (r_state == S_HOLD);

endmodule
